// File: rtl/acc_if.sv
// Bundle between the systolic array and acc_collector: the inbound per-column partial-sum
// strobes and tile control, plus the outbound result-row stream.
interface acc_if #(
    parameter int N      = 4,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32
);
    logic [N-1:0][DATA_W-1:0] psum_i;
    logic [N-1:0]             acc_valid_i;
    logic                     tile_start_i;
    logic                     first_tile_i;
    logic                     last_tile_i;

    // A row moves on every cycle where out_valid_o && out_ready_i. Once out_valid_o is
    // raised, the producer keeps out_row_o/out_last_o stable until that handshake.
    logic                     out_valid_o;
    logic                     out_ready_i;
    logic [N-1:0][ACC_W-1:0]  out_row_o;
    logic                     out_last_o;

    modport slave (
        input  psum_i, acc_valid_i, tile_start_i, first_tile_i, last_tile_i, out_ready_i,
        output out_valid_o, out_row_o, out_last_o
    );

    modport master (
        output psum_i, acc_valid_i, tile_start_i, first_tile_i, last_tile_i, out_ready_i,
        input  out_valid_o, out_row_o, out_last_o
    );
endinterface

// File: rtl/acc_collector.sv
// Deskews per-column partial sums into an NxN result buffer, accumulates across K-tiles,
// and drains finished rows. Define ACC_SATURATE_EN to clamp results instead of wrapping.
module acc_collector #(
    parameter int N      = 4,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    acc_if.slave       acc,
    output logic       busy_o,
    output logic       tile_done_o,
    output logic       err_o,
    output logic [1:0] dbg_state_o
);
    localparam int PTR_W = $clog2(N + 1);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [PTR_W-1:0] FULL_PTR = PTR_W'(N);
    localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    first_q, first_d;
    logic                    last_q, last_d;
    logic [PTR_W-1:0]        wp_q [N];
    logic [PTR_W-1:0]        wp_d [N];
    logic [ACC_W-1:0]        res_q [N][N];
    logic [ACC_W-1:0]        res_d [N][N];
    logic [IDX_W-1:0]        rp_q, rp_d;
    logic                    err_d, tile_done_d, out_valid_d, out_last_d;
    logic [N-1:0][ACC_W-1:0] out_row_d;
    logic [ACC_W:0]          op;
    logic [IDX_W-1:0]        idx;
    logic                    all_full;

    // Returns {saturated, result}; the overwrite case passes base = 0.
    function automatic logic [ACC_W:0] add_op(input logic [ACC_W-1:0]  base,
                                              input logic [DATA_W-1:0] psum);
`ifdef ACC_SATURATE_EN
        logic signed [ACC_W:0] sum;
        sum = (ACC_W+1)'($signed(base)) + (ACC_W+1)'($signed(psum));
        if (sum[ACC_W] != sum[ACC_W-1])
            return {1'b1, sum[ACC_W], {(ACC_W-1){~sum[ACC_W]}}};
        return {1'b0, sum[ACC_W-1:0]};
`else
        return {1'b0, base + ACC_W'($signed(psum))};
`endif
    endfunction

    always_comb begin
        state_d     = state_q;
        first_d     = first_q;
        last_d      = last_q;
        wp_d        = wp_q;
        res_d       = res_q;
        rp_d        = rp_q;
        err_d       = err_o;
        tile_done_d = 1'b0;
        out_valid_d = acc.out_valid_o;
        out_last_d  = acc.out_last_o;
        out_row_d   = acc.out_row_o;
        op          = '0;
        idx         = '0;
        all_full    = 1'b1;
        case (state_q)
            IDLE: begin
                if (|acc.acc_valid_i) err_d = 1'b1;
                if (acc.tile_start_i) begin
                    first_d = acc.first_tile_i;
                    last_d  = acc.last_tile_i;
                    for (int j = 0; j < N; j++) wp_d[j] = '0;
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                for (int j = 0; j < N; j++) begin
                    if (acc.acc_valid_i[j]) begin
                        if (wp_q[j] != FULL_PTR) begin
                            idx = wp_q[j][IDX_W-1:0];
                            op  = add_op(first_q ? '0 : res_q[idx][j], acc.psum_i[j]);
                            res_d[idx][j] = op[ACC_W-1:0];
                            if (op[ACC_W]) err_d = 1'b1;
                            wp_d[j] = wp_q[j] + 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    if (wp_d[j] != FULL_PTR) all_full = 1'b0;
                end
                // Row 0 is loaded from res_d so a write landing on this edge is already visible.
                if (all_full) begin
                    tile_done_d = 1'b1;
                    if (last_q) begin
                        state_d     = DRAIN;
                        rp_d        = '0;
                        out_valid_d = 1'b1;
                        out_last_d  = (LAST_ROW == '0);
                        for (int j = 0; j < N; j++) out_row_d[j] = res_d[0][j];
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DRAIN: begin
                if (|acc.acc_valid_i) err_d = 1'b1;
                if (acc.out_ready_i) begin
                    if (rp_q == LAST_ROW) begin
                        state_d     = IDLE;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        out_row_d   = '0;
                    end else begin
                        rp_d       = rp_q + 1'b1;
                        out_last_d = (rp_d == LAST_ROW);
                        for (int j = 0; j < N; j++) out_row_d[j] = res_q[rp_d][j];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= IDLE;
            first_q         <= 1'b0;
            last_q          <= 1'b0;
            rp_q            <= '0;
            err_o           <= 1'b0;
            tile_done_o     <= 1'b0;
            acc.out_valid_o <= 1'b0;
            acc.out_last_o  <= 1'b0;
            acc.out_row_o   <= '0;
            for (int r = 0; r < N; r++) begin
                wp_q[r] <= '0;
                for (int c = 0; c < N; c++) res_q[r][c] <= '0;
            end
        end else begin
            state_q         <= state_d;
            first_q         <= first_d;
            last_q          <= last_d;
            rp_q            <= rp_d;
            err_o           <= err_d;
            tile_done_o     <= tile_done_d;
            acc.out_valid_o <= out_valid_d;
            acc.out_last_o  <= out_last_d;
            acc.out_row_o   <= out_row_d;
            wp_q            <= wp_d;
            res_q           <= res_d;
        end
    end

    assign busy_o      = (state_q != IDLE);
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_acc_collector.sv
// Directed bench for acc_collector: one 32-bit-accumulator instance for the main flows and a
// 16-bit one for the overflow case (wrap by default, clamp with ACC_SATURATE_EN).
module tb_acc_collector;
  localparam int N      = 4;
  localparam int DATA_W = 16;
  localparam int ACC_W  = 32;
  localparam int SW     = 16;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b1;
  logic       busy_o, tile_done_o, err_o;
  logic [1:0] dbg_state_o;
  logic       busy_s, tile_done_s, err_s;
  logic [1:0] dbg_state_s;

  acc_if #(.N(N), .DATA_W(DATA_W), .ACC_W(ACC_W)) bus ();
  acc_if #(.N(N), .DATA_W(DATA_W), .ACC_W(SW))    bus_s ();

  acc_collector #(.N(N), .DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .acc(bus.slave), .busy_o(busy_o),
    .tile_done_o(tile_done_o), .err_o(err_o), .dbg_state_o(dbg_state_o)
  );

  acc_collector #(.N(N), .DATA_W(DATA_W), .ACC_W(SW)) dut_s (
    .clk_i(clk_i), .rst_ni(rst_ni), .acc(bus_s.slave), .busy_o(busy_s),
    .tile_done_o(tile_done_s), .err_o(err_s), .dbg_state_o(dbg_state_s)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  int checks = 0;
  int passes = 0;
  int done_cnt;
  int extra_col = -1;
  logic [DATA_W-1:0]  extra_val;
  logic [DATA_W-1:0]  tile_vals [N][N];
  logic [N*ACC_W-1:0] exp_q[$];

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_idle();
    bus.psum_i = '0;   bus.acc_valid_i = '0;   bus.tile_start_i = 1'b0;
    bus.first_tile_i = 1'b0; bus.last_tile_i = 1'b0; bus.out_ready_i = 1'b0;
    bus_s.psum_i = '0; bus_s.acc_valid_i = '0; bus_s.tile_start_i = 1'b0;
    bus_s.first_tile_i = 1'b0; bus_s.last_tile_i = 1'b0; bus_s.out_ready_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
    step();
  endtask

  // driver: one tile with column j skewed by j cycles; optional extra strobe on the last cycle
  task automatic collect_tile(input logic first_t, input logic last_t);
    done_cnt = 0;
    bus.tile_start_i = 1'b1; bus.first_tile_i = first_t; bus.last_tile_i = last_t;
    step();
    bus.tile_start_i = 1'b0; bus.first_tile_i = 1'b0; bus.last_tile_i = 1'b0;
    for (int t = 0; t < 2*N-1; t++) begin
      for (int j = 0; j < N; j++) begin
        if (t >= j && t - j < N) begin
          bus.acc_valid_i[j] = 1'b1; bus.psum_i[j] = tile_vals[t-j][j];
        end else begin
          bus.acc_valid_i[j] = 1'b0; bus.psum_i[j] = '0;
        end
      end
      if (t == 2*N-2 && extra_col >= 0) begin
        bus.acc_valid_i[extra_col] = 1'b1; bus.psum_i[extra_col] = extra_val;
      end
      checks++;
      if (busy_o !== 1'b1) $display("FAIL collect_busy t=%0d got %b exp 1", t, busy_o); else passes++;
      step();
      if (tile_done_o === 1'b1) done_cnt++;
    end
    bus.acc_valid_i = '0; bus.psum_i = '0;
    checks++;
    if (tile_done_o !== 1'b1) $display("FAIL tile_done_pulse got %b exp 1", tile_done_o); else passes++;
    checks++;
    if (acc_valid_rise(bus.out_valid_o) !== last_t)
      $display("FAIL drain_entry_valid got %b exp %b", bus.out_valid_o, last_t);
    else passes++;
    checks++;
    if (busy_o !== last_t) $display("FAIL busy_after_collect got %b exp %b", busy_o, last_t); else passes++;
    step();
    if (tile_done_o === 1'b1) done_cnt++;
    checks++;
    if (done_cnt !== 1) $display("FAIL tile_done_count got %0d exp 1", done_cnt); else passes++;
  endtask

  function automatic logic acc_valid_rise(input logic v);
    return v;
  endfunction

  // scoreboard consumer: ready pattern 0 = always, 1 = 1,0,0,1,...
  task automatic drain_rows(input int mode);
    int hs = 0;
    int cyc = 0;
    logic rdy;
    logic [N*ACC_W-1:0] exp_row;
    logic [N*ACC_W-1:0] got_row;
    while (hs < N && cyc < 60) begin
      rdy = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
      bus.out_ready_i = rdy;
      exp_row = (exp_q.size() > 0) ? exp_q[0] : 'x;
      got_row = bus.out_row_o;
      checks++;
      if (bus.out_valid_o !== 1'b1) $display("FAIL drain_valid cyc=%0d got %b exp 1", cyc, bus.out_valid_o); else passes++;
      checks++;
      if (got_row !== exp_row) $display("FAIL drain_row%0d cyc=%0d got %h exp %h", hs, cyc, got_row, exp_row); else passes++;
      checks++;
      if (bus.out_last_o !== (hs == N-1)) $display("FAIL drain_last row%0d got %b exp %b", hs, bus.out_last_o, hs == N-1); else passes++;
      step();
      if (rdy) begin
        exp_row = exp_q.pop_front();
        hs++;
      end
      cyc++;
    end
    bus.out_ready_i = 1'b0;
    checks++;
    if (hs !== N) $display("FAIL drain_handshakes got %0d exp %0d", hs, N); else passes++;
    checks++;
    if (cyc !== ((mode == 0) ? N : 3*(N-1)+1)) $display("FAIL drain_cycles got %0d exp %0d", cyc, (mode == 0) ? N : 3*(N-1)+1); else passes++;
    checks++;
    if ({busy_o, bus.out_valid_o, dbg_state_o} !== 4'b0000)
      $display("FAIL drain_exit busy=%b valid=%b state=%0d exp 0/0/0", busy_o, bus.out_valid_o, dbg_state_o);
    else passes++;
  endtask

  task automatic push_expected(input int base, input int rmul, input int cmul);
    logic [N*ACC_W-1:0] row;
    for (int r = 0; r < N; r++) begin
      for (int j = 0; j < N; j++) row[j*ACC_W +: ACC_W] = ACC_W'(base + rmul*r + cmul*j);
      exp_q.push_back(row);
    end
  endtask

  task automatic test_reset();
    #1 rst_ni = 1'b0;
    #2;
    checks++;
    if ({busy_o, tile_done_o, bus.out_valid_o, bus.out_last_o, err_o, dbg_state_o} !== 7'b0)
      $display("FAIL reset_flags got %b exp 0", {busy_o, tile_done_o, bus.out_valid_o, bus.out_last_o, err_o, dbg_state_o});
    else passes++;
    checks++;
    if (bus.out_row_o !== '0) $display("FAIL reset_row got %h exp 0", bus.out_row_o); else passes++;
    step(); step();
    rst_ni = 1'b1;
    step();
  endtask

  task automatic test_single_tile();
    for (int r = 0; r < N; r++)
      for (int j = 0; j < N; j++) tile_vals[r][j] = DATA_W'(10*r + j);
    push_expected(0, 10, 1);
    collect_tile(1'b1, 1'b1);
    drain_rows(0);
  endtask

  task automatic test_two_tiles();
    for (int r = 0; r < N; r++)
      for (int j = 0; j < N; j++) tile_vals[r][j] = DATA_W'(-3);
    collect_tile(1'b1, 1'b0);
    checks++;
    if ({busy_o, bus.out_valid_o} !== 2'b00) $display("FAIL between_tiles busy=%b valid=%b exp 0/0", busy_o, bus.out_valid_o); else passes++;
    for (int r = 0; r < N; r++)
      for (int j = 0; j < N; j++) tile_vals[r][j] = DATA_W'(5);
    push_expected(2, 0, 0);
    collect_tile(1'b0, 1'b1);
    drain_rows(0);
  endtask

  task automatic test_backpressure();
    for (int r = 0; r < N; r++)
      for (int j = 0; j < N; j++) tile_vals[r][j] = DATA_W'(100*r - 7*j - 50);
    push_expected(-50, 100, -7);
    collect_tile(1'b1, 1'b1);
    drain_rows(1);
  endtask

  task automatic test_overflow_strobe();
    do_reset();
    for (int r = 0; r < N; r++)
      for (int j = 0; j < N; j++) tile_vals[r][j] = DATA_W'(10*r + j + 300);
    extra_col = 2; extra_val = 16'h7777;
    push_expected(300, 10, 1);
    collect_tile(1'b1, 1'b1);
    extra_col = -1;
    checks++;
    if (err_o !== 1'b1) $display("FAIL err_fifth_strobe got %b exp 1", err_o); else passes++;
    drain_rows(0);
    checks++;
    if (err_o !== 1'b1) $display("FAIL err_sticky got %b exp 1", err_o); else passes++;
  endtask

  task automatic test_idle_strobe();
    do_reset();
    checks++;
    if (err_o !== 1'b0) $display("FAIL err_cleared got %b exp 0", err_o); else passes++;
    bus.acc_valid_i[1] = 1'b1; bus.psum_i[1] = 16'd55;
    step();
    bus.acc_valid_i = '0; bus.psum_i = '0;
    step(); step();
    checks++;
    if ({err_o, busy_o} !== 2'b10) $display("FAIL err_idle_strobe err=%b busy=%b exp 1/0", err_o, busy_o); else passes++;
  endtask

  task automatic test_reset_mid_collect();
    do_reset();
    bus.tile_start_i = 1'b1; bus.first_tile_i = 1'b1; bus.last_tile_i = 1'b1;
    step();
    bus.tile_start_i = 1'b0; bus.first_tile_i = 1'b0; bus.last_tile_i = 1'b0;
    bus.acc_valid_i = 4'b0011; bus.psum_i = {16'd0, 16'd0, 16'd999, 16'd999};
    step(); step();
    bus.acc_valid_i = '0; bus.psum_i = '0;
    rst_ni = 1'b0;
    #1;
    checks++;
    if ({busy_o, tile_done_o, bus.out_valid_o, bus.out_last_o, err_o, dbg_state_o} !== 7'b0)
      $display("FAIL midreset_flags got %b exp 0", {busy_o, tile_done_o, bus.out_valid_o, bus.out_last_o, err_o, dbg_state_o});
    else passes++;
    step();
    rst_ni = 1'b1;
    step();
    // accumulate onto the reset buffer: any leftover partial data would show up in the sums
    for (int r = 0; r < N; r++)
      for (int j = 0; j < N; j++) tile_vals[r][j] = DATA_W'(10*r + j);
    push_expected(0, 10, 1);
    collect_tile(1'b0, 1'b1);
    drain_rows(0);
  endtask

  task automatic test_saturation();
    logic [SW-1:0] exp_v;
    logic          exp_e;
`ifdef ACC_SATURATE_EN
    exp_v = 16'h7FFF; exp_e = 1'b1;
`else
    exp_v = 16'h8000; exp_e = 1'b0;
`endif
    do_reset();
    for (int k = 0; k < 2; k++) begin
      bus_s.tile_start_i = 1'b1; bus_s.first_tile_i = (k == 0); bus_s.last_tile_i = (k == 1);
      step();
      bus_s.tile_start_i = 1'b0; bus_s.first_tile_i = 1'b0; bus_s.last_tile_i = 1'b0;
      for (int c = 0; c < N; c++) begin
        bus_s.acc_valid_i = '1;
        for (int j = 0; j < N; j++) bus_s.psum_i[j] = (k == 0) ? 16'h7FFF : 16'h0001;
        step();
      end
      bus_s.acc_valid_i = '0; bus_s.psum_i = '0;
      checks++;
      if ({tile_done_s, busy_s} !== {1'b1, k == 1}) $display("FAIL sat_tile%0d_done done=%b busy=%b", k, tile_done_s, busy_s); else passes++;
      if (k == 0) begin
        checks++;
        if (err_s !== 1'b0) $display("FAIL sat_overwrite_err got %b exp 0", err_s); else passes++;
        step();
      end
    end
    bus_s.out_ready_i = 1'b1;
    for (int r = 0; r < N; r++) begin
      checks++;
      if (bus_s.out_valid_o !== 1'b1 || bus_s.out_row_o !== {N{exp_v}})
        $display("FAIL sat_row%0d got %h valid %b exp %h", r, bus_s.out_row_o, bus_s.out_valid_o, {N{exp_v}});
      else passes++;
      step();
    end
    bus_s.out_ready_i = 1'b0;
    checks++;
    if ({err_s, busy_s} !== {exp_e, 1'b0}) $display("FAIL sat_err err=%b busy=%b exp %b/0", err_s, busy_s, exp_e); else passes++;
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_single_tile();
    test_two_tiles();
    test_backpressure();
    test_overflow_strobe();
    test_idle_strobe();
    test_reset_mid_collect();
    test_saturation();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/acc_collector.md
# acc_collector

Receiving end of the systolic array's accumulator interface. Captures the skewed per-column partial sums leaving the bottom PE row, qualified by the controller's per-column accumulator-valid strobes. Deskews them into an N×N result buffer, optionally accumulating across K-tiles. Drains finished rows to downstream logic over a valid/ready handshake.

## Interface
- `N`, 4, array dimension (rows = columns).
- `DATA_W`, 16, signed partial-sum width from a PE column.
- `ACC_W`, 32, signed accumulator/result width; `ACC_W >= DATA_W`.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `psum_i[N]`  in  DATA_W each  bottom-row partial sums, one per column.
- `acc_valid_i[N]`  in  1 each  per-column strobe: `psum_i[j]` is valid this cycle.
- `tile_start_i`  in  1  one-cycle pulse that begins collection of one tile.
- `first_tile_i`  in  1  sampled with `tile_start_i`: 1 = overwrite buffer, 0 = add to buffer.
- `last_tile_i`  in  1  sampled with `tile_start_i`: 1 = drain after collection.
- `busy_o`  out  1  high in COLLECT or DRAIN.
- `tile_done_o`  out  1  one-cycle pulse at the end of collection.
- `out_valid_o`  out  1  result row available.
- `out_ready_i`  in  1  downstream accepts row.
- `out_row_o[N]`  out  ACC_W each  result row r, element j = C[r][j].
- `out_last_o`  out  1  high with row N-1.
- `err_o`  out  1  sticky protocol error; cleared only by reset.

## Operation
- States: IDLE, COLLECT, DRAIN.
- **IDLE**
  - `tile_start_i` latches `first_tile_i`/`last_tile_i`, clears all column pointers `wp[j]` to 0, and moves to COLLECT.
- **COLLECT**
  - On `acc_valid_i[j]` with `wp[j] < N`: `buf[wp[j]][j]` ← `sext(psum_i[j])` if first tile, else `buf[wp[j]][j] + sext(psum_i[j])`. Then `wp[j]++`.
  - Columns are independent. Any subset of columns may strobe in the same cycle.
  - A column is complete when `wp[j] == N`. A strobe on a complete column is ignored and sets `err_o`.
  - When all columns are complete: pulse `tile_done_o`, then go to DRAIN if `last_tile_i` was latched, else to IDLE.
- **DRAIN**
  - Row pointer `rp` starts at 0. `out_row_o = buf[rp]`, `out_valid_o = 1`, `out_last_o = (rp == N-1)`.
  - On `out_valid_o && out_ready_i`: `rp++`. After row N-1 is accepted, go to IDLE.
  - The row is held stable while `out_ready_i` is low.
- Arithmetic: psums are sign-extended to ACC_W. Without saturation, the add wraps modulo 2^ACC_W.
- Illegal or ignored inputs:
  - `tile_start_i` outside IDLE is ignored (no error).
  - `acc_valid_i` in IDLE or DRAIN is ignored and sets `err_o`.

## Timing
- Reset (async assert, synchronous deassert by the flops' clocking):
  - State IDLE; all pointers and buffer entries 0.
  - `busy_o`, `tile_done_o`, `out_valid_o`, `out_last_o`, `err_o` = 0; `out_row_o` = 0.
- Reset mid-COLLECT or mid-DRAIN aborts immediately; partial data is discarded.
- Buffer write takes effect at the clock edge where the strobe is sampled.
- `tile_done_o` is asserted the cycle after the final column's last write; the state change happens on that same edge.
- In DRAIN, `out_valid_o` rises the cycle after the final write and is registered.
  - At full throughput (`out_ready_i` held high), one row per cycle: N cycles to drain.
  - `busy_o` falls the cycle after the last handshake.
- `tile_start_i` is accepted in the first IDLE cycle after DRAIN/COLLECT exits. Back-to-back tiles therefore have a 1-cycle minimum gap.
- `out_*` outputs are driven only from flops.

## Configuration
- `ACC_SATURATE_EN` defined:
  - Each accumulate and overwrite saturates to [−2^(ACC_W−1), 2^(ACC_W−1)−1].
  - Any saturation event also sets `err_o`.
- Not defined: two's-complement wrap; saturation logic absent.

## Test plan
- N=4, one tile, first=last=1. Column j strobes four times with values 10·r+j, skewed one cycle per column. → `tile_done_o` pulses once; four rows drain with row r = {10r, 10r+1, 10r+2, 10r+3}; `out_last_o` on row 3.
- Two tiles, the second with first=0, all psums = −3 then +5. → Drained rows all equal 2; the first tile produces no DRAIN, `busy_o` drops between tiles.
- Drain with `out_ready_i` toggling 1,0,0,1,… → Each row is held stable while not ready; exactly four handshakes; return to IDLE.
- Fifth strobe on column 2 after its four writes, plus a strobe in IDLE. → Both ignored, `err_o`=1 and stays high; buffer contents unchanged.
- Assert `rst_ni` low after two writes in COLLECT. → All outputs 0 immediately. The next tile yields correct data uncontaminated by the partial one.
- With `ACC_SATURATE_EN`, ACC_W=16, accumulate 0x7FFF + 0x0001. → Result 0x7FFF and `err_o`=1. Without the macro → result 0x8000 and `err_o`=0.
